nios_project_hex_driver: RTL and testbench

NIOS_PROJECT_HEX_DRIVER -- requirements
Module: nios_project_hex_driver

---
 rtl/nios_project_hex_driver.sv | 143 ++++++++++++++
 tb/tb_nios_project_hex_driver.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_project_hex_driver.sv
// Seven-segment driver with Avalon-MM control, PWM brightness and optional blink.
// Define NIOS_PROJECT_HEX_DRIVER_BLINK_EN to build the blink prescaler and phase logic.
module nios_project_hex_driver #(
    parameter int unsigned PWM_BITS   = 4,
    parameter int unsigned BLINK_DIV  = 20,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  seg_in,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [6:0]  hex_out
);

    localparam logic [6:0] SegMask = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    logic                wr_en;
    logic                enable_q, enable_d;
    logic [PWM_BITS-1:0] bright_q, bright_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [6:0]          seg_q;
    logic                sticky_q, sticky_d;
    logic [6:0]          hex_q, hex_d;
    logic                pwm_on;
    logic                visible;
    logic                blink_en;
    logic                phase;
    logic [7:0]          rate_rd;
    logic                unused_wdata;

    assign wr_en        = chipselect && !write_n;
    assign unused_wdata = ^writedata;

`ifdef NIOS_PROJECT_HEX_DRIVER_BLINK_EN
    logic                 blink_en_q, blink_en_d;
    logic [7:0]           rate_q, rate_d;
    logic [BLINK_DIV-1:0] presc_q, presc_d;
    logic [7:0]           blink_cnt_q, blink_cnt_d;
    logic                 phase_q, phase_d;
    logic                 tick;

    assign tick = (presc_q == '1);

    always_comb begin
        blink_en_d  = blink_en_q;
        rate_d      = rate_q;
        presc_d     = presc_q + BLINK_DIV'(1);
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (wr_en && address == 2'd0) blink_en_d = writedata[1];
        if (wr_en && address == 2'd2) rate_d = writedata[7:0];
        // Parking in the lit phase makes every blink enable start visible.
        if (!blink_en_q) begin
            phase_d     = 1'b1;
            blink_cnt_d = 8'd0;
        end else if (tick) begin
            if (blink_cnt_q == rate_q) begin
                phase_d     = ~phase_q;
                blink_cnt_d = 8'd0;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            blink_en_q  <= 1'b0;
            rate_q      <= 8'h0F;
            presc_q     <= '0;
            blink_cnt_q <= 8'd0;
            phase_q     <= 1'b1;
        end else begin
            blink_en_q  <= blink_en_d;
            rate_q      <= rate_d;
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign blink_en = blink_en_q;
    assign phase    = phase_q;
    assign rate_rd  = rate_q;
`else
    localparam int unsigned UnusedBlinkDiv = BLINK_DIV;

    assign blink_en = 1'b0;
    assign phase    = 1'b1;
    assign rate_rd  = 8'h00;
`endif

    assign pwm_on  = (bright_q == '1) || (pwm_cnt_q < bright_q);
    assign visible = enable_q && pwm_on && (!blink_en || phase);

    always_comb begin
        enable_d  = enable_q;
        bright_d  = bright_q;
        sticky_d  = sticky_q;
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        hex_d     = (visible ? seg_q : 7'h00) ^ SegMask;
        if (wr_en && address == 2'd0) enable_d = writedata[0];
        if (wr_en && address == 2'd1) bright_d = writedata[PWM_BITS-1:0];
        if (wr_en && address == 2'd3 && writedata[1]) sticky_d = 1'b0;
        // A new change overrides a clear landing in the same cycle.
        if (seg_in != seg_q) sticky_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            enable_q  <= 1'b1;
            bright_q  <= '1;
            pwm_cnt_q <= '0;
            seg_q     <= 7'h00;
            sticky_q  <= 1'b0;
            hex_q     <= SegMask;
        end else begin
            enable_q  <= enable_d;
            bright_q  <= bright_d;
            pwm_cnt_q <= pwm_cnt_d;
            seg_q     <= seg_in;
            sticky_q  <= sticky_d;
            hex_q     <= hex_d;
        end
    end

    always_comb begin
        readdata = 32'h0;
        case (address)
            2'd0:    readdata[1:0] = {blink_en, enable_q};
            2'd1:    readdata[PWM_BITS-1:0] = bright_q;
            2'd2:    readdata[7:0] = rate_rd;
            default: readdata[1:0] = {sticky_q, phase};
        endcase
    end

    assign hex_out = hex_q;

endmodule

// File: tb/tb_nios_project_hex_driver.sv
// Randomized bench for nios_project_hex_driver with a timing-level model of the display rules.
// Follows NIOS_PROJECT_HEX_DRIVER_BLINK_EN the same way the design does.
module tb_nios_project_hex_driver;

    localparam int unsigned PwmBits  = 2;
    localparam int unsigned BlinkDiv = 2;
    localparam int          PwmMax   = (1 << PwmBits) - 1;
    localparam int          PreLen   = 1 << BlinkDiv;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  seg_in;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [6:0]  hex_out;

    int checks = 0;
    int errors = 0;
    int n = 0;        // clock edges since reset released
    int m_bright;

    nios_project_hex_driver #(
        .PWM_BITS  (PwmBits),
        .BLINK_DIV (BlinkDiv),
        .ACTIVE_LOW(1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .seg_in    (seg_in),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .hex_out   (hex_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset_n) n <= 0;
        else n <= n + 1;
    end

    function automatic bit pwm_lit(int b, int cnt);
        return (b == PwmMax) || ((cnt % (PwmMax + 1)) < b);
    endfunction

    function automatic logic [6:0] exp_hex(bit vis, logic [6:0] s);
        return (vis ? s : 7'h00) ^ 7'h7F;
    endfunction

    // Number of prescaler wrap cycles among edge counts a..b.
    function automatic int ticks_between(int a, int b);
        return (b + 1) / PreLen - a / PreLen;
    endfunction

    // Phase after edge count m, with blink enabled at edge count ne.
    function automatic bit blink_phase(int ne, int m, int rate);
        return ((ticks_between(ne, m - 1) / (rate + 1)) % 2) == 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic av_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic av_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset_n = 1'b0;
        seg_in  = 7'h3F;
        repeat (3) tick();
        checks++;
        if (hex_out !== 7'h7F) begin
            errors++;
            $display("FAIL reset_hex: got %h want %h", hex_out, 7'h7F);
        end
        av_write(2'd0, 32'h0);
        av_write(2'd1, 32'h0);
        seg_in = 7'h00;
        tick();
        checks++;
        if (hex_out !== 7'h7F) begin
            errors++;
            $display("FAIL reset_hex_hold: got %h want %h", hex_out, 7'h7F);
        end
        reset_n = 1'b1;
        m_bright = PwmMax;
        av_read(2'd0, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL reset_ctrl: got %h want %h", rd, 32'h1);
        end
        av_read(2'd1, rd);
        checks++;
        if (rd !== 32'(PwmMax)) begin
            errors++;
            $display("FAIL reset_bright: got %h want %h", rd, PwmMax);
        end
        av_read(2'd2, rd);
        checks++;
`ifdef NIOS_PROJECT_HEX_DRIVER_BLINK_EN
        if (rd !== 32'h0F) begin
            errors++;
            $display("FAIL reset_rate: got %h want %h", rd, 32'h0F);
        end
`else
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL reset_rate: got %h want %h", rd, 32'h0);
        end
`endif
        av_read(2'd3, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL reset_status: got %h want %h", rd, 32'h1);
        end
        seg_in = 7'h3F;
        tick();
        checks++;
        if (hex_out !== 7'h7F) begin
            errors++;
            $display("FAIL latency_1: got %h want %h", hex_out, 7'h7F);
        end
        tick();
        checks++;
        if (hex_out !== 7'h40) begin
            errors++;
            $display("FAIL latency_2: got %h want %h", hex_out, 7'h40);
        end
    endtask

    task automatic test_pwm();
        int          blist[5];
        logic [31:0] rd;
        logic [6:0]  prev, cur, exp;
        blist[0] = 1;
        blist[1] = 0;
        blist[2] = PwmMax;
        blist[3] = int'($urandom_range(0, PwmMax));
        blist[4] = int'($urandom_range(0, PwmMax));
        prev = seg_in;
        foreach (blist[k]) begin
            av_write(2'd1, ($urandom & ~32'(PwmMax)) | 32'(blist[k]));
            m_bright = blist[k];
            av_read(2'd1, rd);
            checks++;
            if (rd !== 32'(blist[k])) begin
                errors++;
                $display("FAIL bright_rd: got %h want %h", rd, blist[k]);
            end
            for (int i = 0; i < 16; i++) begin
                cur    = 7'($urandom);
                seg_in = cur;
                tick();
                exp = exp_hex(pwm_lit(m_bright, n - 1), prev);
                checks++;
                if (hex_out !== exp) begin
                    errors++;
                    $display("FAIL pwm_hex b=%0d n=%0d: got %h want %h", m_bright, n, hex_out,
                             exp);
                end
                prev = cur;
            end
        end
        av_write(2'd1, 32'(PwmMax));
        m_bright = PwmMax;
    endtask

    task automatic test_sticky();
        logic [31:0] rd;
        logic [6:0]  v, same;
        seg_in = 7'h06;
        repeat (2) tick();
        av_write(2'd3, $urandom | 32'h2);
        av_read(2'd3, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL sticky_clear0: got %h want %h", rd, 32'h1);
        end
        seg_in = 7'h5B;
        tick();
        av_read(2'd3, rd);
        checks++;
        if (rd !== 32'h3) begin
            errors++;
            $display("FAIL sticky_set: got %h want %h", rd, 32'h3);
        end
        av_write(2'd3, 32'h2);
        av_read(2'd3, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL sticky_w1c: got %h want %h", rd, 32'h1);
        end
        do v = 7'($urandom); while (v == 7'h5B);
        seg_in = v;
        av_write(2'd3, 32'h2);
        av_read(2'd3, rd);
        checks++;
        if (rd !== 32'h3) begin
            errors++;
            $display("FAIL sticky_set_wins: got %h want %h", rd, 32'h3);
        end
        av_write(2'd3, 32'h2);
        for (int i = 0; i < 8; i++) begin
            same   = seg_in;
            v      = ($urandom_range(0, 1) == 1) ? same : 7'($urandom);
            seg_in = v;
            tick();
            av_read(2'd3, rd);
            checks++;
            if (rd !== {30'h0, v != same, 1'b1}) begin
                errors++;
                $display("FAIL sticky_rand: got %h want %h", rd, {30'h0, v != same, 1'b1});
            end
            av_write(2'd3, 32'h2);
        end
    endtask

`ifdef NIOS_PROJECT_HEX_DRIVER_BLINK_EN
    task automatic test_blink();
        logic [31:0] rd;
        logic [6:0]  prev, cur, exp;
        int          ne;
        av_write(2'd2, ($urandom & ~32'hFF) | 32'h1);
        av_read(2'd2, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL rate_rd: got %h want %h", rd, 32'h1);
        end
        prev = seg_in;
        av_write(2'd0, 32'h3);
        ne = n;
        for (int i = 0; i < 40; i++) begin
            cur    = 7'($urandom);
            seg_in = cur;
            tick();
            av_read(2'd3, rd);
            checks++;
            if (rd[0] !== blink_phase(ne, n, 1)) begin
                errors++;
                $display("FAIL blink_phase n=%0d: got %b want %b", n, rd[0],
                         blink_phase(ne, n, 1));
            end
            exp = exp_hex(blink_phase(ne, n - 1, 1), prev);
            checks++;
            if (hex_out !== exp) begin
                errors++;
                $display("FAIL blink_hex n=%0d: got %h want %h", n, hex_out, exp);
            end
            prev = cur;
        end
        av_write(2'd0, 32'h1);
        tick();
        av_read(2'd3, rd);
        checks++;
        if (rd[0] !== 1'b1) begin
            errors++;
            $display("FAIL blink_off_phase: got %b want 1", rd[0]);
        end
        prev = seg_in;
        for (int i = 0; i < 8; i++) begin
            cur    = 7'($urandom);
            seg_in = cur;
            tick();
            checks++;
            if (hex_out !== exp_hex(1'b1, prev)) begin
                errors++;
                $display("FAIL blink_off_hex: got %h want %h", hex_out, exp_hex(1'b1, prev));
            end
            prev = cur;
        end
        av_write(2'd0, 32'h3);
        repeat ($urandom_range(9, 20)) tick();
        reset_n = 1'b0;
        tick();
        av_read(2'd3, rd);
        checks++;
        if (rd[0] !== 1'b1 || hex_out !== 7'h7F) begin
            errors++;
            $display("FAIL midblink_reset: got phase %b hex %h want 1 7f", rd[0], hex_out);
        end
        reset_n  = 1'b1;
        m_bright = PwmMax;
        av_read(2'd0, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL midblink_ctrl: got %h want %h", rd, 32'h1);
        end
    endtask
`else
    task automatic test_no_blink();
        logic [31:0] rd;
        logic [6:0]  prev, cur;
        av_write(2'd2, 32'h05);
        av_write(2'd0, 32'h3);
        av_read(2'd2, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL noblink_rate: got %h want %h", rd, 32'h0);
        end
        av_read(2'd0, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL noblink_ctrl: got %h want %h", rd, 32'h1);
        end
        prev = seg_in;
        for (int i = 0; i < 40; i++) begin
            cur    = 7'($urandom);
            seg_in = cur;
            tick();
            av_read(2'd3, rd);
            checks++;
            if (rd[0] !== 1'b1) begin
                errors++;
                $display("FAIL noblink_phase: got %b want 1", rd[0]);
            end
            checks++;
            if (hex_out !== exp_hex(pwm_lit(m_bright, n - 1), prev)) begin
                errors++;
                $display("FAIL noblink_hex: got %h want %h", hex_out,
                         exp_hex(pwm_lit(m_bright, n - 1), prev));
            end
            prev = cur;
        end
    endtask
`endif

    task automatic test_enable();
        logic [31:0] rd;
        av_write(2'd0, $urandom & ~32'h3);
        tick();
        checks++;
        if (hex_out !== 7'h7F) begin
            errors++;
            $display("FAIL enable_off: got %h want %h", hex_out, 7'h7F);
        end
        for (int i = 0; i < 8; i++) begin
            seg_in = 7'($urandom);
            tick();
            checks++;
            if (hex_out !== 7'h7F) begin
                errors++;
                $display("FAIL enable_blank: got %h want %h", hex_out, 7'h7F);
            end
        end
        av_read(2'd0, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL enable_ctrl: got %h want %h", rd, 32'h0);
        end
        av_read(2'd1, rd);
        checks++;
        if (rd !== 32'(m_bright)) begin
            errors++;
            $display("FAIL enable_bright: got %h want %h", rd, m_bright);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        seg_in     = 7'h00;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        #1;
        test_reset();
        test_pwm();
        test_sticky();
`ifdef NIOS_PROJECT_HEX_DRIVER_BLINK_EN
        test_blink();
`else
        test_no_blink();
`endif
        test_enable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
